pixel_stream_tx: RTL and testbench

- Frame source for the 8-bit pixel-stream filter chain.
- Reads a stored grayscale image from an external synchronous-read frame memory in raster order.
- Drives the dat/val stream consumed by the filter stages: one pixel per clock within a line, configurable horizontal and vertical blanking between lines and after the frame.
- Started by a single-cycle command; reports busy and done.

---
 rtl/pix_tx_pkg.sv | 25 ++
 rtl/pix_tx_timing.sv | 132 +++++++++++++
 rtl/pixel_stream_tx.sv | 102 ++++++++++
 tb/tb_pixel_stream_tx.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pix_tx_pkg.sv
// Shared types and helpers for the pixel-stream frame source.
// Optional build macro PIX_TX_PATTERN_EN is consumed by pixel_stream_tx.
package pix_tx_pkg;

    localparam int unsigned PIX_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLine,
        StHblk,
        StVblk,
        StDone
    } pix_tx_state_e;

    // Ceiling log2, never less than 1 so counters always have a real bit.
    function automatic int unsigned clog2(input int unsigned val);
        int unsigned res;
        res = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(val)) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pix_tx_timing.sv
// Frame timing engine: FSM, raster counters, memory read strobe/address and
// pre-aligned sof/eol markers for the data stage in pixel_stream_tx.
module pix_tx_timing
    import pix_tx_pkg::*;
#(
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256,
    parameter int unsigned HBLANK = 4,
    parameter int unsigned VBLANK = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned XW     = clog2(IMG_W),
    parameter int unsigned YW     = clog2(IMG_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              start_ack_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              line_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              sof_o,
    output logic              eol_o,
    output logic [XW-1:0]     x_o,
    output logic [YW-1:0]     y_o
);

    localparam int unsigned BW = clog2(((HBLANK > VBLANK) ? HBLANK : VBLANK) + 1);

    pix_tx_state_e     state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [BW-1:0]     blk_q, blk_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              line_q, line_d;
    logic              sof_q, sof_d;
    logic              eol_q, eol_d;

    assign start_ack_o = (state_q == StIdle) && start_i;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        blk_d   = blk_q;
        addr_d  = addr_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLine;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                end
            end
            StLine: begin
                addr_d = addr_q + ADDR_W'(1);
                if (x_q == XW'(IMG_W - 1)) begin
                    x_d   = '0;
                    blk_d = '0;
                    if (y_q == YW'(IMG_H - 1)) begin
                        state_d = StVblk;
                    end else begin
                        y_d     = y_q + YW'(1);
                        state_d = (HBLANK > 0) ? StHblk : StLine;
                    end
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            StHblk: begin
                if (blk_q == BW'(HBLANK - 1)) state_d = StLine;
                else blk_d = blk_q + BW'(1);
            end
            // VBLANK+1 cycles here: the first overlaps the last pixel's data stage.
            StVblk: begin
                if (blk_q == BW'(VBLANK)) state_d = StDone;
                else blk_d = blk_q + BW'(1);
            end
            StDone: begin
                state_d = StIdle;
                addr_d  = '0;
                y_d     = '0;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
        line_d = (state_d == StLine);
        sof_d  = line_d && (addr_d == '0);
        eol_d  = line_d && (x_d == XW'(IMG_W - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            blk_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            line_q  <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            blk_q   <= blk_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            line_q  <= line_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign line_o = line_q;
    assign addr_o = addr_q;
    assign sof_o  = sof_q;
    assign eol_o  = eol_q;
    assign x_o    = x_q;
    assign y_o    = y_q;

endmodule

// File: rtl/pixel_stream_tx.sv
// Frame source for the pixel-stream filter chain: timing engine plus data stage.
// Define PIX_TX_PATTERN_EN to add pattern_sel_i and the internal (x+y) test pattern.
module pixel_stream_tx
    import pix_tx_pkg::*;
#(
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256,
    parameter int unsigned HBLANK = 4,
    parameter int unsigned VBLANK = 16,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
`ifdef PIX_TX_PATTERN_EN
    input  logic              pattern_sel_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [PIX_W-1:0]  mem_dat_i,
    output logic [PIX_W-1:0]  dat_o,
    output logic              val_o,
    output logic              sof_o,
    output logic              eol_o
);

    localparam int unsigned XW = clog2(IMG_W);
    localparam int unsigned YW = clog2(IMG_H);

    logic             start_ack, line, sof_pre, eol_pre;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic             pat_q, pat_d;
    logic             val_q, sof_q, eol_q;
    logic [PIX_W-1:0] pat_dat_q, pat_dat_d;
    logic [PIX_W-1:0] hold_q, hold_d;
    logic [PIX_W-1:0] dat;

    pix_tx_timing #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .HBLANK (HBLANK),
        .VBLANK (VBLANK),
        .ADDR_W (ADDR_W),
        .XW     (XW),
        .YW     (YW)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .start_ack_o (start_ack),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .line_o      (line),
        .addr_o      (mem_addr_o),
        .sof_o       (sof_pre),
        .eol_o       (eol_pre),
        .x_o         (x),
        .y_o         (y)
    );

`ifdef PIX_TX_PATTERN_EN
    assign pat_d = start_ack ? pattern_sel_i : pat_q;
`else
    assign pat_d = start_ack & 1'b0;
`endif

    // Memory data arrives in the val_o cycle, so it is passed through rather than
    // registered; the hold register keeps dat_o stable between pixels.
    always_comb begin
        pat_dat_d = PIX_W'(x) + PIX_W'(y);
        dat       = val_q ? (pat_q ? pat_dat_q : mem_dat_i) : hold_q;
        hold_d    = dat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q     <= 1'b0;
            val_q     <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            pat_dat_q <= '0;
            hold_q    <= '0;
        end else begin
            pat_q     <= pat_d;
            val_q     <= line;
            sof_q     <= sof_pre;
            eol_q     <= eol_pre;
            pat_dat_q <= pat_dat_d;
            hold_q    <= hold_d;
        end
    end

    assign mem_rd_o = line & ~pat_q;
    assign dat_o    = dat;
    assign val_o    = val_q;
    assign sof_o    = sof_q;
    assign eol_o    = eol_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Self-checking bench for pixel_stream_tx: two instances (with and without blanking)
// compared cycle by cycle against an arithmetic frame-timing model.
module tb_pixel_stream_tx;

    localparam int W = 4;
    localparam int H = 3;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic        busy_a, done_a, rd_a, val_a, sof_a, eol_a;
    logic        busy_b, done_b, rd_b, val_b, sof_b, eol_b;
    logic [15:0] addr_a, addr_b;
    logic [7:0]  mdat_a, mdat_b, dat_a, dat_b;
`ifdef PIX_TX_PATTERN_EN
    logic        pat_sel;
`endif

    logic [7:0]  mem [16];
    logic [7:0]  e_hold_a, e_hold_b;
    int          checks, failures;

    pixel_stream_tx #(
        .IMG_W (W), .IMG_H (H), .HBLANK (2), .VBLANK (3), .ADDR_W (16)
    ) dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_a),
`ifdef PIX_TX_PATTERN_EN
        .pattern_sel_i (pat_sel),
`endif
        .busy_o        (busy_a),
        .done_o        (done_a),
        .mem_rd_o      (rd_a),
        .mem_addr_o    (addr_a),
        .mem_dat_i     (mdat_a),
        .dat_o         (dat_a),
        .val_o         (val_a),
        .sof_o         (sof_a),
        .eol_o         (eol_a)
    );

    pixel_stream_tx #(
        .IMG_W (W), .IMG_H (H), .HBLANK (0), .VBLANK (0), .ADDR_W (16)
    ) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_b),
`ifdef PIX_TX_PATTERN_EN
        .pattern_sel_i (1'b0),
`endif
        .busy_o        (busy_b),
        .done_o        (done_b),
        .mem_rd_o      (rd_b),
        .mem_addr_o    (addr_b),
        .mem_dat_i     (mdat_b),
        .dat_o         (dat_b),
        .val_o         (val_b),
        .sof_o         (sof_b),
        .eol_o         (eol_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read frame memory, one cycle latency.
    always @(posedge clk) begin
        if (rd_a) mdat_a <= mem[addr_a[3:0]];
        if (rd_b) mdat_b <= mem[addr_b[3:0]];
    end

    // Raster index of the pixel on val_o 'rel' cycles after the start cycle, else -1.
    function automatic int pix_at(input int rel, input int hb);
        int p, per;
        p   = rel - 2;
        per = W + hb;
        if (p < 0) return -1;
        if (p / per >= H || p % per >= W) return -1;
        return (p / per) * W + p % per;
    endfunction

    function automatic int done_at(input int hb, input int vb);
        return 2 + (H - 1) * (W + hb) + (W - 1) + vb + 1;
    endfunction

    // Expected {busy, done, mem_rd, val, sof, eol}.
    function automatic logic [5:0] exp_ctl(input int rel, input int hb, input int vb,
                                           input bit pat);
        int idx, nidx, d;
        idx  = pix_at(rel, hb);
        nidx = pix_at(rel + 1, hb);
        d    = done_at(hb, vb);
        return {rel >= 1 && rel <= d, rel == d, nidx >= 0 && !pat, idx >= 0, idx == 0,
                idx >= 0 && idx % W == W - 1};
    endfunction

    function automatic logic [7:0] exp_pix(input int idx, input bit pat);
        if (pat) return 8'(idx % W + idx / W);
        return mem[4'(idx)];
    endfunction

    task automatic fill_mem;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        start_a = 1'b1;
        start_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({busy_a, done_a, rd_a, val_a, sof_a, eol_a, addr_a, dat_a} !== 30'd0) begin
                failures++;
                $display("FAIL reset_a cyc=%0d got ctl=%b addr=%h dat=%h want all zero", c,
                         {busy_a, done_a, rd_a, val_a, sof_a, eol_a}, addr_a, dat_a);
            end
            checks++;
            if ({busy_b, done_b, rd_b, val_b, sof_b, eol_b, addr_b, dat_b} !== 30'd0) begin
                failures++;
                $display("FAIL reset_b cyc=%0d got ctl=%b addr=%h dat=%h want all zero", c,
                         {busy_b, done_b, rd_b, val_b, sof_b, eol_b}, addr_b, dat_b);
            end
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        e_hold_a = 8'd0;
        e_hold_b = 8'd0;
    endtask

    task automatic test_frame;
        int idx;
        logic [5:0] e;
        fill_mem();
        for (int c = 0; c < 25; c++) begin
            start_a = (c == 0);
            @(negedge clk);
            idx = pix_at(c, 2);
            e   = exp_ctl(c, 2, 3, 1'b0);
            if (idx >= 0) e_hold_a = exp_pix(idx, 1'b0);
            checks++;
            if ({busy_a, done_a, rd_a, val_a, sof_a, eol_a} !== e) begin
                failures++;
                $display("FAIL frame_ctl cyc=%0d got=%b want=%b", c,
                         {busy_a, done_a, rd_a, val_a, sof_a, eol_a}, e);
            end
            checks++;
            if (dat_a !== e_hold_a) begin
                failures++;
                $display("FAIL frame_dat cyc=%0d got=%h want=%h", c, dat_a, e_hold_a);
            end
            if (e[3]) begin
                checks++;
                if (addr_a !== 16'(pix_at(c + 1, 2))) begin
                    failures++;
                    $display("FAIL frame_addr cyc=%0d got=%0d want=%0d", c, addr_a,
                             pix_at(c + 1, 2));
                end
            end
            @(posedge clk);
            #1;
        end
        start_a = 1'b0;
    endtask

    task automatic test_start_ignored;
        int idx;
        logic [5:0] e;
        fill_mem();
        for (int c = 0; c < 25; c++) begin
            start_a = (c == 0) || (c == 5) || (c == 21) ||
                      (c > 0 && c < 22 && $urandom_range(0, 2) == 0);
            @(negedge clk);
            idx = pix_at(c, 2);
            e   = exp_ctl(c, 2, 3, 1'b0);
            if (idx >= 0) e_hold_a = exp_pix(idx, 1'b0);
            checks++;
            if ({busy_a, done_a, rd_a, val_a, sof_a, eol_a} !== e) begin
                failures++;
                $display("FAIL ignore_ctl cyc=%0d got=%b want=%b", c,
                         {busy_a, done_a, rd_a, val_a, sof_a, eol_a}, e);
            end
            checks++;
            if (dat_a !== e_hold_a) begin
                failures++;
                $display("FAIL ignore_dat cyc=%0d got=%h want=%h", c, dat_a, e_hold_a);
            end
            @(posedge clk);
            #1;
        end
        start_a = 1'b0;
    endtask

    task automatic test_reset_mid;
        int r, rel, idx;
        logic [5:0] e;
        fill_mem();
        r = int'($urandom_range(4, 18));
        for (int c = 0; c < r + 3 + 24; c++) begin
            start_a = (c == 0) || (c == r + 3);
            rst_n   = (c != r);
            @(negedge clk);
            rel = (c <= r) ? c : c - (r + 3);
            if (c == r + 1) e_hold_a = 8'd0;
            idx = pix_at(rel, 2);
            e   = exp_ctl(rel, 2, 3, 1'b0);
            if (idx >= 0) e_hold_a = exp_pix(idx, 1'b0);
            checks++;
            if ({busy_a, done_a, rd_a, val_a, sof_a, eol_a} !== e) begin
                failures++;
                $display("FAIL rstmid_ctl cyc=%0d r=%0d got=%b want=%b", c, r,
                         {busy_a, done_a, rd_a, val_a, sof_a, eol_a}, e);
            end
            checks++;
            if (dat_a !== e_hold_a) begin
                failures++;
                $display("FAIL rstmid_dat cyc=%0d r=%0d got=%h want=%h", c, r, dat_a,
                         e_hold_a);
            end
            if (c == r + 1 || e[3]) begin
                checks++;
                if (addr_a !== ((c == r + 1) ? 16'd0 : 16'(pix_at(rel + 1, 2)))) begin
                    failures++;
                    $display("FAIL rstmid_addr cyc=%0d r=%0d got=%0d", c, r, addr_a);
                end
            end
            @(posedge clk);
            #1;
        end
        start_a = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_no_blank;
        int idx;
        logic [5:0] e;
        fill_mem();
        for (int c = 0; c < 18; c++) begin
            start_b = (c == 0);
            @(negedge clk);
            idx = pix_at(c, 0);
            e   = exp_ctl(c, 0, 0, 1'b0);
            if (idx >= 0) e_hold_b = exp_pix(idx, 1'b0);
            checks++;
            if ({busy_b, done_b, rd_b, val_b, sof_b, eol_b} !== e) begin
                failures++;
                $display("FAIL noblank_ctl cyc=%0d got=%b want=%b", c,
                         {busy_b, done_b, rd_b, val_b, sof_b, eol_b}, e);
            end
            checks++;
            if (dat_b !== e_hold_b) begin
                failures++;
                $display("FAIL noblank_dat cyc=%0d got=%h want=%h", c, dat_b, e_hold_b);
            end
            if (e[3]) begin
                checks++;
                if (addr_b !== 16'(pix_at(c + 1, 0))) begin
                    failures++;
                    $display("FAIL noblank_addr cyc=%0d got=%0d want=%0d", c, addr_b,
                             pix_at(c + 1, 0));
                end
            end
            @(posedge clk);
            #1;
        end
        start_b = 1'b0;
    endtask

`ifdef PIX_TX_PATTERN_EN
    task automatic test_pattern;
        int idx;
        logic [5:0] e;
        fill_mem();
        pat_sel = 1'b1;
        for (int c = 0; c < 25; c++) begin
            start_a = (c == 0);
            @(negedge clk);
            idx = pix_at(c, 2);
            e   = exp_ctl(c, 2, 3, 1'b1);
            if (idx >= 0) e_hold_a = exp_pix(idx, 1'b1);
            checks++;
            if ({busy_a, done_a, rd_a, val_a, sof_a, eol_a} !== e) begin
                failures++;
                $display("FAIL pattern_ctl cyc=%0d got=%b want=%b", c,
                         {busy_a, done_a, rd_a, val_a, sof_a, eol_a}, e);
            end
            checks++;
            if (dat_a !== e_hold_a) begin
                failures++;
                $display("FAIL pattern_dat cyc=%0d got=%h want=%h", c, dat_a, e_hold_a);
            end
            @(posedge clk);
            #1;
            pat_sel = 1'($urandom);
        end
        start_a = 1'b0;
        pat_sel = 1'b0;
    endtask
`endif

    task automatic test_back_to_back;
        int rel, idx;
        logic [5:0] e;
        fill_mem();
        for (int c = 0; c < 47; c++) begin
            start_a = (c < 43);
            @(negedge clk);
            rel = (c < 22) ? c : c - 22;
            idx = pix_at(rel, 2);
            e   = exp_ctl(rel, 2, 3, 1'b0);
            if (idx >= 0) e_hold_a = exp_pix(idx, 1'b0);
            checks++;
            if ({busy_a, done_a, rd_a, val_a, sof_a, eol_a} !== e) begin
                failures++;
                $display("FAIL b2b_ctl cyc=%0d got=%b want=%b", c,
                         {busy_a, done_a, rd_a, val_a, sof_a, eol_a}, e);
            end
            checks++;
            if (dat_a !== e_hold_a) begin
                failures++;
                $display("FAIL b2b_dat cyc=%0d got=%h want=%h", c, dat_a, e_hold_a);
            end
            if (e[3]) begin
                checks++;
                if (addr_a !== 16'(pix_at(rel + 1, 2))) begin
                    failures++;
                    $display("FAIL b2b_addr cyc=%0d got=%0d want=%0d", c, addr_a,
                             pix_at(rel + 1, 2));
                end
            end
            @(posedge clk);
            #1;
        end
        start_a = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        e_hold_a = 8'd0;
        e_hold_b = 8'd0;
`ifdef PIX_TX_PATTERN_EN
        pat_sel  = 1'b0;
`endif
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        test_reset();
        test_frame();
        test_start_ignored();
        test_reset_mid();
        test_no_blank();
`ifdef PIX_TX_PATTERN_EN
        test_pattern();
`endif
        test_back_to_back();
        test_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
